// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all downstream domains in reset, then releases them
// one at a time in index order, waiting for each domain's ready acknowledge.
module rst_seq_ctrl #(
  parameter int NUM_DOMAINS = 3,
  parameter int IDX_W       = 2,
  parameter int DLY_W       = 8,
  parameter int HOLD_CYCLES = 16,
  parameter int TIMEOUT     = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   soft_rst_req,
  input  logic [DLY_W-1:0]       dly_cfg,
  input  logic [NUM_DOMAINS-1:0] dom_ready,
  output logic [NUM_DOMAINS-1:0] dom_rst_n,
  output logic                   seq_busy,
  output logic                   seq_done,
  output logic                   fault,
  output logic [IDX_W-1:0]       fault_idx
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] S_HOLD  = 3'd0;
  localparam logic [2:0] S_GAP   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  logic [2:0]             state, state_nx;
  logic [IDX_W-1:0]       idx, idx_nx;
  logic [HOLD_W-1:0]      hold_cnt, hold_nx;
  logic [DLY_W-1:0]       gap_cnt, gap_nx;
  logic [TO_W-1:0]        to_cnt, to_nx;
  logic [DLY_W-1:0]       d_lat;
  logic                   dlat_load;
  logic [NUM_DOMAINS-1:0] rst_n_nx;
  logic                   fault_nx;
  logic [IDX_W-1:0]       fidx_nx;
  logic [NUM_DOMAINS-1:0] rel_mask;
  logic                   ready_cur;

  // Decode the current domain index into a release mask and its ready bit
  always_comb begin
    rel_mask  = '0;
    ready_cur = 1'b0;
    for (int k = 0; k < NUM_DOMAINS; k++) begin
      if (idx == IDX_W'(k)) begin
        rel_mask[k] = 1'b1;
        ready_cur   = dom_ready[k];
      end
    end
  end

  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    hold_nx   = hold_cnt;
    gap_nx    = gap_cnt;
    to_nx     = to_cnt;
    rst_n_nx  = dom_rst_n;
    fault_nx  = fault;
    fidx_nx   = fault_idx;
    dlat_load = 1'b0;
    case (state)
      S_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          state_nx  = S_GAP;
          idx_nx    = '0;
          gap_nx    = '0;
          dlat_load = 1'b1;
        end else begin
          hold_nx = hold_cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt == d_lat) begin
          state_nx = S_WAIT;
          rst_n_nx = dom_rst_n | rel_mask;
          to_nx    = '0;
        end else begin
          gap_nx = gap_cnt + 1'b1;
        end
      end
      S_WAIT: begin
        if (ready_cur) begin
          if (idx == IDX_LAST) begin
            state_nx = S_DONE;
            rst_n_nx = '1;
          end else begin
            state_nx  = S_GAP;
            idx_nx    = idx + 1'b1;
            gap_nx    = '0;
            dlat_load = 1'b1;
          end
        end else if (to_cnt == TO_LAST) begin
          // Drop every domain back into reset so nothing runs half-initialised
          state_nx = S_FAULT;
          rst_n_nx = '0;
          fault_nx = 1'b1;
          fidx_nx  = idx;
        end else begin
          to_nx = to_cnt + 1'b1;
        end
      end
      S_DONE:  state_nx = S_DONE;
      S_FAULT: state_nx = S_FAULT;
      default: state_nx = S_HOLD;
    endcase
    if (soft_rst_req) begin
      state_nx  = S_HOLD;
      idx_nx    = '0;
      hold_nx   = '0;
      gap_nx    = '0;
      to_nx     = '0;
      rst_n_nx  = '0;
      fault_nx  = 1'b0;
      fidx_nx   = '0;
      dlat_load = 1'b0;
    end
  end

  // State/status register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_HOLD;
      idx       <= '0;
      hold_cnt  <= '0;
      gap_cnt   <= '0;
      to_cnt    <= '0;
      dom_rst_n <= '0;
      seq_busy  <= 1'b1;
      seq_done  <= 1'b0;
      fault     <= 1'b0;
      fault_idx <= '0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      hold_cnt  <= hold_nx;
      gap_cnt   <= gap_nx;
      to_cnt    <= to_nx;
      dom_rst_n <= rst_n_nx;
      seq_busy  <= (state_nx == S_HOLD) || (state_nx == S_GAP) || (state_nx == S_WAIT);
      seq_done  <= (state_nx == S_DONE);
      fault     <= fault_nx;
      fault_idx <= fidx_nx;
    end
  end

  // Gap length is a configuration value captured only on GAP entry
  always_ff @(posedge clk) begin
    if (dlat_load && !rst) d_lat <= dly_cfg;
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench for rst_seq_ctrl: the driver queues expected output changes
// with their cycle numbers; the monitor pops one per observed output change.
module tb_rst_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       soft_rst_req = 1'b0;
  logic [7:0] dly_cfg = 8'd4;
  logic [2:0] dom_ready = 3'b111;
  logic [2:0] dom_rst_n;
  logic       seq_busy, seq_done, fault;
  logic [1:0] fault_idx;

  rst_seq_ctrl #(
    .NUM_DOMAINS(3), .IDX_W(2), .DLY_W(8), .HOLD_CYCLES(16), .TIMEOUT(255)
  ) dut (
    .clk(clk), .rst(rst), .soft_rst_req(soft_rst_req), .dly_cfg(dly_cfg),
    .dom_ready(dom_ready), .dom_rst_n(dom_rst_n), .seq_busy(seq_busy),
    .seq_done(seq_done), .fault(fault), .fault_idx(fault_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // {dom_rst_n, seq_busy, seq_done, fault, fault_idx}
  localparam logic [7:0] V_RST = 8'b000_1_0_0_00;
  localparam logic [7:0] V_E1  = 8'b001_1_0_0_00;
  localparam logic [7:0] V_E2  = 8'b011_1_0_0_00;
  localparam logic [7:0] V_E3  = 8'b111_1_0_0_00;
  localparam logic [7:0] V_DN  = 8'b111_0_1_0_00;
  localparam logic [7:0] V_F1  = 8'b000_0_0_1_01;

  typedef struct {
    int         t;
    logic [7:0] v;
    string      name;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  bit  mon_en = 1'b0;
  logic [7:0] prev = 8'bx;

  task automatic push(input int t, input logic [7:0] v, input string name);
    ev_t e;
    e.t = t; e.v = v; e.name = name;
    exp_q.push_back(e);
  endtask

  // Monitor: every change of the output vector must match the next queued event
  always @(negedge clk) begin
    logic [7:0] snap;
    ev_t e;
    snap = {dom_rst_n, seq_busy, seq_done, fault, fault_idx};
    if (mon_en && (snap !== prev)) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_change cyc=%0d got=%b none queued", cyc, snap);
      end else begin
        e = exp_q.pop_front();
        if ((e.t != cyc) || (e.v !== snap)) begin
          bad++;
          $display("FAIL %s got cyc=%0d val=%b want cyc=%0d val=%b",
                   e.name, cyc, snap, e.t, e.v);
        end
      end
      prev = snap;
    end
  end

  task automatic goto_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_at(input int t, input bit r, input bit s, output int b);
    goto_cyc(t);
    rst = r;
    soft_rst_req = s;
    @(posedge clk);
    #1;
    rst = 1'b0;
    soft_rst_req = 1'b0;
    b = cyc;
  endtask

  task automatic drain(input int t, input string name);
    goto_cyc(t);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s pending=%0d want 0 (next %s at cyc %0d)",
               name, exp_q.size(), exp_q[0].name, exp_q[0].t);
      exp_q.delete();
    end
  endtask

  initial begin
    int b, b2;
    // Power-on reset, D=4, all ready
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    b = cyc;
    push(b, V_RST, "por_reset_state");
    push(b + 21, V_E1, "d4_rel0");
    push(b + 27, V_E2, "d4_rel1");
    push(b + 33, V_E3, "d4_rel2");
    push(b + 34, V_DN, "d4_done");
    mon_en = 1'b1;
    drain(b + 40, "d4_drain");

    // Soft reset from DONE, minimum gap D=0
    dly_cfg = 8'd0;
    pulse_at(cyc + 2, 1'b0, 1'b1, b);
    push(b, V_RST, "soft_from_done");
    push(b + 17, V_E1, "d0_rel0");
    push(b + 19, V_E2, "d0_rel1");
    push(b + 21, V_E3, "d0_rel2");
    push(b + 22, V_DN, "d0_done");
    drain(b + 30, "d0_drain");

    // Domain 1 never acknowledges: timeout fault
    dly_cfg = 8'd4;
    dom_ready = 3'b101;
    pulse_at(cyc + 2, 1'b1, 1'b0, b);
    push(b, V_RST, "rst_from_done");
    push(b + 21, V_E1, "to_rel0");
    push(b + 27, V_E2, "to_rel1");
    push(b + 282, V_F1, "timeout_fault");
    drain(b + 290, "to_drain");

    // Soft reset from FAULT; ready arrives on the last allowed cycle
    pulse_at(cyc + 2, 1'b0, 1'b1, b);
    push(b, V_RST, "soft_from_fault");
    push(b + 21, V_E1, "late_rel0");
    push(b + 27, V_E2, "late_rel1");
    push(b + 287, V_E3, "late_rel2");
    push(b + 288, V_DN, "late_done");
    goto_cyc(b + 281);
    dom_ready = 3'b111;
    goto_cyc(b + 290);
    dom_ready = 3'b000;
    drain(b + 300, "late_drain_ready_dropped");

    // rst and soft together during WAIT_ACK, then dly_cfg changed mid-gap
    pulse_at(cyc + 2, 1'b0, 1'b1, b);
    push(b, V_RST, "soft_from_done2");
    push(b + 21, V_E1, "wait_rel0");
    pulse_at(b + 25, 1'b1, 1'b1, b2);
    push(b2, V_RST, "rst_soft_same_cycle");
    dom_ready = 3'b111;
    push(b2 + 21, V_E1, "dchg_rel0");
    push(b2 + 24, V_E2, "dchg_rel1");
    push(b2 + 27, V_E3, "dchg_rel2");
    push(b2 + 28, V_DN, "dchg_done");
    goto_cyc(b2 + 18);
    dly_cfg = 8'd1;
    drain(b2 + 35, "dchg_drain");

    // rst during GAP of domain 2 restarts from HOLD
    dly_cfg = 8'd4;
    pulse_at(cyc + 2, 1'b1, 1'b0, b);
    push(b, V_RST, "rst_from_done2");
    push(b + 21, V_E1, "mid_rel0");
    push(b + 27, V_E2, "mid_rel1");
    pulse_at(b + 30, 1'b1, 1'b0, b2);
    dly_cfg = 8'd0;
    push(b2, V_RST, "rst_in_gap2");
    push(b2 + 17, V_E1, "restart_rel0");
    push(b2 + 19, V_E2, "restart_rel1");
    push(b2 + 21, V_E3, "restart_rel2");
    push(b2 + 22, V_DN, "restart_done");
    drain(b2 + 30, "restart_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
- Reset sequencer placed after the reset synchronizer, in the same clock domain as its synchronized output.
- Holds NUM_DOMAINS downstream subsystems in reset, then releases them one at a time in index order (0 first).
- A programmable gap separates each release. After each release the block waits for that domain's ready acknowledge, with a timeout.
- Supports a software-requested re-sequence and reports done/busy/fault status to the control unit.

Parameters:
NUM_DOMAINS, 3, number of sequenced reset domains (>=1)
IDX_W, 2, width of domain index; 2**IDX_W >= NUM_DOMAINS
DLY_W, 8, width of inter-release gap configuration
HOLD_CYCLES, 16, cycles all domains are held in reset before sequencing starts (>=1)
TIMEOUT, 255, max WAIT_ACK cycles per domain before fault (>=1)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset (driven from synchronized reset)
soft_rst_req  input  1  single-cycle pulse; restart full sequence
dly_cfg  input  DLY_W  gap length D; the gap lasts D+1 cycles
dom_ready  input  NUM_DOMAINS  per-domain ready acknowledge, level
dom_rst_n  output  NUM_DOMAINS  per-domain active-low reset, registered
seq_busy  output  1  sequence in progress (HOLD/GAP/WAIT_ACK)
seq_done  output  1  all domains released and acknowledged
fault  output  1  sticky; a domain failed to acknowledge in time
fault_idx  output  IDX_W  index of the failing domain

Behaviour:
- Reset (rst=1 at clock edge):
  - state=HOLD; dom_rst_n=all 0; seq_busy=1; seq_done=0; fault=0; fault_idx=0.
  - Index, gap counter and timeout counter all cleared to 0.
- Priority: rst > soft_rst_req > normal transitions.
- States: HOLD, GAP, WAIT_ACK, DONE, FAULT.
  - HOLD: all dom_rst_n=0. Stays exactly HOLD_CYCLES cycles (the first cycle after rst drops counts as cycle 0). Then -> GAP with idx=0.
  - GAP:
    - dly_cfg is latched on GAP entry; later changes have no effect until the next GAP.
    - Lasts latched D+1 cycles. D=0 gives a 1-cycle gap.
    - On exit: dom_rst_n[idx]<=1, timeout counter cleared, -> WAIT_ACK.
  - WAIT_ACK:
    - dom_ready[idx] is sampled from the first WAIT_ACK cycle.
    - If dom_ready[idx]=1 and idx=NUM_DOMAINS-1 -> DONE.
    - If dom_ready[idx]=1 and idx<NUM_DOMAINS-1 -> idx+1, GAP.
    - If no ready by WAIT_ACK cycle TIMEOUT-1 -> FAULT next cycle. Ready on cycle TIMEOUT-1 is still accepted.
  - DONE: dom_rst_n=all 1; seq_done=1; seq_busy=0. Later deassertion of any dom_ready is ignored. Stays until rst or soft_rst_req.
  - FAULT:
    - On entry: dom_rst_n forced all 0 (safe state); fault=1; fault_idx=failing idx; seq_busy=0; seq_done=0.
    - Stays until rst or soft_rst_req.
- soft_rst_req=1 in any state:
  - Next cycle: state=HOLD; dom_rst_n=all 0; seq_busy=1; seq_done=0; fault=0; fault_idx=0; counters cleared.
  - Any same-cycle transition is overridden.
  - A request during HOLD restarts the HOLD count.
- Once released, dom_rst_n[k] stays 1 until DONE exit, FAULT entry, soft_rst_req or rst. Only one domain is released per GAP exit. Releases are never out of order.
- dom_ready of non-current domains is don't-care.
- Timing with immediate ready, H=HOLD_CYCLES, D=dly_cfg, cycle 0 = first cycle after rst low:
  - dom_rst_n[k] rises at cycle H+(k+1)(D+1)+k.
  - seq_done rises at cycle H+NUM_DOMAINS*(D+2).
- All outputs are registered; no combinational input-to-output paths.

Test Plan:
- Defaults, dly_cfg=4, dom_ready=3'b111, rst released at cycle 0 -> dom_rst_n[0]/[1]/[2] rise at cycles 21/27/33; seq_done=1, seq_busy=0 at cycle 34.
- dly_cfg=0, dom_ready=all 1 -> releases at 17/19/21, seq_done at 22; verifies 1-cycle minimum gap.
- dom_ready[1] held 0 -> WAIT_ACK for domain 1 entered at 27; fault=1, fault_idx=1, dom_rst_n=000 at 282. dom_ready[1] rising at 281 instead -> accepted, no fault.
- soft_rst_req pulse while in FAULT, then while in DONE -> next cycle fault=0, seq_done=0, dom_rst_n=000, seq_busy=1; full sequence repeats with identical timing relative to the pulse.
- soft_rst_req and rst asserted the same cycle during WAIT_ACK -> reset values. dly_cfg changed mid-GAP -> current gap length unchanged, new value used for the next gap.
- Mid-sequence rst during GAP of domain 2 -> all dom_rst_n=0 next cycle; sequence restarts from HOLD with idx=0.
